// File: rtl/alu_dispatch.sv
// alu_dispatch: execute-stage register driving the ALU, plus a 2-entry in-order result buffer for writeback
module alu_dispatch #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_ope,
    input  logic [31:0]     in_ds,
    input  logic [31:0]     in_dt,
    input  logic [RD_W-1:0] in_rd,
    output logic [2:0]      alu_ope,
    output logic [31:0]     alu_ds,
    output logic [31:0]     alu_dt,
    input  logic [31:0]     alu_dd,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            busy,
    output logic [31:0]     wb_count
);
    logic            e_valid;
    logic [2:0]      e_ope;
    logic [31:0]     e_ds;
    logic [31:0]     e_dt;
    logic [RD_W-1:0] e_rd;
    logic [RD_W-1:0] buf_rd [2];
    logic [31:0]     buf_data [2];
    logic            rptr;
    logic            wptr;
    logic [1:0]      count;
    logic [RD_W-1:0] last_rd;
    logic [31:0]     last_data;
    logic            writing;
    logic            wb_pop;
    logic            e_retire;
    logic            push;
    logic            accept;

    assign wb_valid = count != 2'd0;
    assign wb_rd    = wb_valid ? buf_rd[rptr] : last_rd;
    assign wb_data  = wb_valid ? buf_data[rptr] : last_data;
    assign alu_ope  = e_valid ? e_ope : 3'b000;
    assign alu_ds   = e_ds;
    assign alu_dt   = e_dt;
    assign busy     = e_valid | wb_valid;

    // Handshake decisions: a non-writing op always retires, a writing one needs a free or freeing slot
    always_comb begin
        writing  = (e_ope != 3'b000) && (e_ope != 3'b111) && (e_rd != '0);
        wb_pop   = wb_valid & wb_ready;
        e_retire = e_valid & (!writing | (count < 2'd2) | wb_pop);
        push     = e_retire & writing;
        in_ready = !flush & (!e_valid | e_retire);
        accept   = in_valid & in_ready;
    end

    // Execute register: loads on accept, empties on retire or flush; operands hold when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= 1'b0;
            e_ope   <= 3'b000;
            e_ds    <= '0;
            e_dt    <= '0;
            e_rd    <= '0;
        end else if (accept) begin
            e_valid <= 1'b1;
            e_ope   <= in_ope;
            e_ds    <= in_ds;
            e_dt    <= in_dt;
            e_rd    <= in_rd;
        end else if (e_retire | flush) begin
            e_valid <= 1'b0;
        end
    end

    // Result buffer, last-popped holding value and handshake counter
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= 2'd0;
            rptr        <= 1'b0;
            wptr        <= 1'b0;
            last_rd     <= '0;
            last_data   <= '0;
            wb_count    <= '0;
            buf_rd[0]   <= '0;
            buf_rd[1]   <= '0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
        end else begin
            if (wb_pop) begin
                wb_count  <= wb_count + 32'd1;
                last_rd   <= wb_rd;
                last_data <= wb_data;
            end
            if (flush) begin
                count <= 2'd0;
                rptr  <= 1'b0;
                wptr  <= 1'b0;
            end else begin
                if (push) begin
                    buf_rd[wptr]   <= e_rd;
                    buf_data[wptr] <= alu_dd;
                    wptr           <= ~wptr;
                end
                if (wb_pop) rptr <= ~rptr;
                count <= count + {1'b0, push} - {1'b0, wb_pop};
            end
        end
    end
endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Execute-stage front end for the integer ALU: accepts decoded ALU operations over a valid/ready handshake and registers them into an execute stage. It drives the combinational ALU's `ope`/`ds`/`dt` inputs, captures its `dd` result, and presents in-order results to register-file writeback through a 2-entry result buffer with backpressure. It sits between the decode/register-read stage and the writeback port.

## Interface
- `RD_W`, default 5: destination register index width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous; discards all in-flight operations.
- `in_valid`  in  1  upstream operation valid.
- `in_ready`  out  1  stage can accept an operation this cycle.
- `in_ope`  in  3  ALU opcode: 001 add, 010 sub, 011 sll, 100 srl, 101 sra, 110 lui; 000 and 111 are no-ops.
- `in_ds`  in  32  first operand.
- `in_dt`  in  32  second operand or immediate.
- `in_rd`  in  RD_W  destination register.
- `alu_ope`  out  3  opcode to the ALU; 000 when the execute stage is empty.
- `alu_ds`  out  32  operand to the ALU, registered.
- `alu_dt`  out  32  operand to the ALU, registered.
- `alu_dd`  in  32  ALU result (combinational from `alu_*`).
- `wb_valid`  out  1  result available at the buffer head.
- `wb_ready`  in  1  writeback consumes the head this cycle.
- `wb_rd`  out  RD_W  destination of the head entry.
- `wb_data`  out  32  result of the head entry.
- `busy`  out  1  execute stage or result buffer is non-empty.
- `wb_count`  out  32  count of completed writeback handshakes; wraps modulo 2^32.

## Operation
- Execute register E holds `e_valid`, `ope`, `ds`, `dt`, and `rd`. `alu_ope = e_valid ? e_ope : 3'b000`. `alu_ds`/`alu_dt` come directly from E and hold their last values when E is empty.
- Writing op: `e_ope` is in {001..110} and `e_rd != 0`. All other ops (opcode 000/111, or `rd == 0`) are dropped at retire and produce no writeback.
- Result buffer: 2 entries, circular, with 1-bit read and write pointers and a 2-bit `count` in 0..2. Order is strictly FIFO.
- `wb_pop = wb_valid & wb_ready`. `wb_valid = (count != 0)`. `wb_rd`/`wb_data` show the head entry. When the buffer is empty they hold the last popped value (0 after reset).
- `e_retire = e_valid & (!writing | count < 2 | wb_pop)`.
- A writing op's retire pushes `{e_rd, alu_dd}` into the buffer.
- A push and a pop in the same cycle at `count == 2` is legal; `count` stays 2.
- `in_ready = !flush & (!e_valid | e_retire)`. This is combinational from `wb_ready`.
- On `in_valid & in_ready`, E loads the input fields and `e_valid` is set. On retire with no accept, `e_valid` clears.
- `busy = e_valid | (count != 0)`.
- `wb_count` increments on every `wb_pop`.
- Flush: E and buffer are cleared at the edge (`e_valid = 0`, `count = 0`, pointers = 0). A pop in the flush cycle still counts in `wb_count`. `in_ready` is 0 during the flush cycle.
- Reset (including mid-operation): every output and register goes to 0 (`e_valid`, `count`, pointers, E fields, `wb_rd`, `wb_data`, `wb_count`). `in_ready` reads 1 in the cycle after reset deasserts. Reset has priority over flush.

## Timing
- Accept at edge k → E valid and the ALU driven during cycle k→k+1 → result pushed at edge k+1 → `wb_valid` high after edge k+1. Latency is 2 edges from accept to `wb_valid`.
- With `wb_ready` held high, throughput is 1 op/cycle with no bubbles.
- With `wb_ready` held low: 3 writing ops are absorbed (E + 2 buffer entries). `in_ready` then falls combinationally and rises in the same cycle `wb_ready` returns.
- No-op and `rd == 0` ops retire in 1 cycle regardless of buffer state.

## Test plan
- Reset, then accept add `ds = 5`, `dt = 7`, `rd = 3` with `wb_ready = 1`. Required: `alu_ope = 001` for one cycle; `wb_valid` 2 edges after accept with `wb_rd = 3`, `wb_data = 12`; `wb_count = 1`.
- Back-to-back lui (`ds = 0x00001234`, `dt = 0x0000ABCD`, `rd = 1`), sra (`ds = 0x80000000`, `dt = 4`, `rd = 2`), sub (`ds = 0`, `dt = 1`, `rd = 4`). Required: results `0xABCD1234`, `0xF8000000`, `0xFFFFFFFF` in order on consecutive cycles.
- `wb_ready = 0`, offer 4 writing ops. Required: 3 accepted, `in_ready = 0` with `count = 2`. Raise `wb_ready`: all 4 written back in order, with no loss or duplication.
- Offer ope 000 (`rd = 5`), ope 111, and add with `rd = 0` while the buffer is full. Required: each accepted and retired in 1 cycle, no `wb_valid` for them, `wb_count` unchanged.
- With E valid and `count = 2`, assert `flush` for 1 cycle. Required: `in_ready = 0` that cycle; next cycle `wb_valid = 0`, `busy = 0`, `alu_ope = 000`.
- Assert `rst` mid-stream with the buffer full. Required: all outputs 0 next cycle, including `wb_count`; `in_ready = 1` after deassert.
